// File: rtl/wide_add_seq_if.sv
// rtl/wide_add_seq_if.sv - command/result bundle for the wide add/subtract sequencer
// Optional macro: WIDE_ADD_OVF_EN adds the ovf result bit.
// Signals:
//   start  command strobe, sampled only while busy=0
//   sub    1 = a-b, 0 = a+b+cin
//   cin    carry-in for add, ignored for subtract
//   a, b   WIDTH-bit operands, sampled on an accepted start
//   busy   high while beats are in progress
//   done   one-cycle completion pulse
//   sum    WIDTH-bit result, held until the next completion
//   cout   final carry-out (for subtract: 1 = no borrow)
//   ovf    signed overflow (only with WIDE_ADD_OVF_EN)
// Modports: master = command source/consumer, slave = sequencer.

interface wide_add_seq_if #(
   parameter int NWORDS = 4
);
   localparam int WIDTH = 16 * NWORDS;

   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef WIDE_ADD_OVF_EN
   logic             ovf;

   modport master (
      output start, sub, cin, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, cin, a, b,
      output busy, done, sum, cout, ovf
   );
`else
   modport master (
      output start, sub, cin, a, b,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, sub, cin, a, b,
      output busy, done, sum, cout
   );
`endif

endinterface

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - WIDTH-bit add/subtract sequenced through one 16-bit carry-select slice
// Optional macro: WIDE_ADD_OVF_EN enables the signed-overflow output bus.ovf.
// Ports:
//   clk  rising-edge system clock
//   rst  asynchronous active-high reset
//   bus  wide_add_seq_if.slave: start/sub/cin/a/b in, busy/done/sum/cout(/ovf) out
// One 16-bit word is processed per clock, least significant word first; the
// carry between words lives in carry_q. Latency is NWORDS cycles from accept.

module carsel_adder (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        ci,
   output logic [15:0] s,
   output logic        co
);
   logic [8:0] lo;
   logic [8:0] hi0;
   logic [8:0] hi1;

   // Upper byte is computed for both possible carries, then selected by the
   // lower byte's carry-out.
   assign lo  = {1'b0, x[7:0]} + {1'b0, y[7:0]} + {8'd0, ci};
   assign hi0 = {1'b0, x[15:8]} + {1'b0, y[15:8]};
   assign hi1 = {1'b0, x[15:8]} + {1'b0, y[15:8]} + 9'd1;

   assign s  = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
   assign co = lo[8] ? hi1[8] : hi0[8];
endmodule

module wide_add_seq #(
   parameter int NWORDS = 4
) (
   input  logic         clk,
   input  logic         rst,
   wide_add_seq_if.slave bus
);
   localparam int WIDTH = 16 * NWORDS;
   localparam int CW    = $clog2(NWORDS);
   localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q,  state_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic [WIDTH-1:0] opa_q,    opa_d;
   logic [WIDTH-1:0] opb_q,    opb_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] sum_q,    sum_d;
   logic             carry_q,  carry_d;
   logic             cout_q,   cout_d;
   logic             done_q,   done_d;
`ifdef WIDE_ADD_OVF_EN
   logic             ovf_q,    ovf_d;
`endif

   logic [15:0] add_s;
   logic        add_co;

   carsel_adder u_slice (
      .x  (opa_q[15:0]),
      .y  (opb_q[15:0]),
      .ci (carry_q),
      .s  (add_s),
      .co (add_co)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      shadow_d = shadow_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      done_d   = 1'b0;
`ifdef WIDE_ADD_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               // Subtract as a + ~b + 1.
               opa_d   = bus.a;
               opb_d   = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ? 1'b1 : bus.cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Result words enter at the top so the LSW ends at bit 0 after
            // NWORDS shifts.
            shadow_d = {add_s, shadow_q[WIDTH-1:16]};
            opa_d    = opa_q >> 16;
            opb_d    = opb_q >> 16;
            carry_d  = add_co;
            if (cnt_q == LAST) begin
               sum_d   = shadow_d;
               cout_d  = add_co;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
`ifdef WIDE_ADD_OVF_EN
               // Carry into the MSB recovered from the MSB's sum bit.
               ovf_d   = (opa_q[15] ^ opb_q[15] ^ add_s[15]) ^ add_co;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         shadow_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         shadow_q <= shadow_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         done_q   <= done_d;
`ifdef WIDE_ADD_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
`ifdef WIDE_ADD_OVF_EN
   assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - scoreboard bench for wide_add_seq with NWORDS=4

module tb_wide_add_seq;
   localparam int NWORDS = 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   exp_t exp_q[$];

   wide_add_seq_if #(.NWORDS(NWORDS)) bus ();

   wide_add_seq #(.NWORDS(NWORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: pops one expected result per done pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               e = exp_q.pop_front();
               chk("sum", bus.sum, e.sum);
               chk("cout", {63'd0, bus.cout}, {63'd0, e.cout});
`ifdef WIDE_ADD_OVF_EN
               chk("ovf", {63'd0, bus.ovf}, {63'd0, e.ovf});
`endif
            end
         end
      end
   end

   task automatic drive(input logic s, input logic c, input logic [63:0] av, input logic [63:0] bv);
      bus.start = 1'b1;
      bus.sub   = s;
      bus.cin   = c;
      bus.a     = av;
      bus.b     = bv;
   endtask

   task automatic idle_inputs();
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.cin   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
   endtask

   task automatic wait_done(input string name);
      int lat;
      lat = 0;
      while (!bus.done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk(name, lat, NWORDS);
   endtask

   task automatic run_op(input logic s, input logic c, input logic [63:0] av, input logic [63:0] bv,
                         input logic [63:0] es, input logic ec, input logic eo);
      exp_t e;
      @(negedge clk);
      chk("idle_before_start", {63'd0, bus.busy}, 64'd0);
      drive(s, c, av, bv);
      e.sum = es; e.cout = ec; e.ovf = eo;
      exp_q.push_back(e);
      @(negedge clk);
      // Operands change right after acceptance and must not matter.
      drive(~s, ~c, ~av, ~bv);
      bus.start = 1'b0;
      chk("busy_after_accept", {63'd0, bus.busy}, 64'd1);
      chk("no_early_done", {63'd0, bus.done}, 64'd0);
      wait_done("latency");
   endtask

   initial begin
      exp_t e;
      logic [63:0] held;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_done", {63'd0, bus.done}, 64'd0);
      chk("rst_sum", bus.sum, 64'd0);
      chk("rst_cout", {63'd0, bus.cout}, 64'd0);
      rst = 1'b0;

      run_op(1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111,
             64'h2345_6789_ABCD_F001, 1'b0, 1'b0);

      // Abort after two beats; carry register holds 1 at that point.
      @(negedge clk);
      drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
      @(negedge clk);
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", {63'd0, bus.busy}, 64'd0);
      chk("abort_done", {63'd0, bus.done}, 64'd0);
      chk("abort_sum", bus.sum, 64'd0);
      chk("abort_cout", {63'd0, bus.cout}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(1'b0, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1,
             64'h0000_0000_0001_0000, 1'b0, 1'b0);
      run_op(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1'b1, 1'b0);
      run_op(1'b1, 1'b1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      run_op(1'b1, 1'b0, 64'd7, 64'd5, 64'd2, 1'b1, 1'b0);
      run_op(1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
      run_op(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd1,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

      // start hammered during RUN, then held into the done cycle.
      held = 64'h7FFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      drive(1'b0, 1'b0, 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040);
      e.sum = 64'h0011_0022_0033_0044; e.cout = 1'b0; e.ovf = 1'b0;
      exp_q.push_back(e);
      for (int k = 0; k < NWORDS; k++) begin
         @(negedge clk);
         chk("run_busy", {63'd0, bus.busy}, 64'd1);
         chk("sum_stable", bus.sum, held);
         drive(k[0], 1'b1, 64'hFFFF_FFFF_FFFF_FFFF - 64'(k), 64'hFFFF_0000_FFFF_0000 + 64'(k));
      end
      @(negedge clk);
      chk("first_done", {63'd0, bus.done}, 64'd1);
      drive(1'b1, 1'b0, 64'd100, 64'd1);
      e.sum = 64'd99; e.cout = 1'b1; e.ovf = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      idle_inputs();
      chk("b2b_accepted", {63'd0, bus.busy}, 64'd1);
      chk("done_one_cycle", {63'd0, bus.done}, 64'd0);
      wait_done("b2b_latency");

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
